pid_step_sequencer: RTL and testbench
=====================================

Name: pid_step_sequencer

Overview:
- Sequences one PID control step per sample period for the TEC temperature loop.
- Each step: pulses a CMOS temperature read, waits for the reading with a timeout, shifts the 3-deep temperature history, and time-multiplexes the three coefficient products through one shared pipelined multiplier.
- Accumulates the products, then quantizes the sum to a signed 4-bit drive step `du`.
- Replaces three parallel multipliers with one scheduled multiplier.

Parameters:
- SAMPLE_DIV, 20000000: sample period in CLK cycles (1 s at 20 MHz).
- TIMEOUT_CYC, 1000: maximum number of cycles spent in WAIT for `temp_valid`.
- MULT_LAT, 3: shared multiplier pipeline latency, in cycles (≥1).
- TEMP_INIT, 16'h7183: reset value of the temperature history (25 °C).

Ports:
- CLK  in  1  system clock, 20 MHz.
- rst  in  1  synchronous reset, active-high.
- enable  in  1  run enable for the sample timer.
- pid_param  in  24  [19:12] Kp (reserved, unused), [11:8] Ti, [7:4] Td, [3:0] T; [23:20] reserved.
- target_temp  in  16  setpoint, unsigned sensor code.
- read_cmos_temp  out  1  one-cycle read request to the sensor interface.
- temp_valid  in  1  sensor reading valid strobe.
- temp_data  in  16  sensor reading, unsigned.
- du  out  4  signed drive step.
- du_valid  out  1  one-cycle strobe, `du`/`p_sum` updated.
- p_sum  out  21  signed saturated product sum of the last step.
- busy  out  1  high in any state except IDLE.
- timeout_err  out  1  sticky; set on a WAIT timeout.
- overrun_err  out  1  sticky; set when a tick arrives while busy.
- err_clr  in  1  clears both sticky flags.

Behaviour:
- Interface: one clock (CLK). Reset `rst` is synchronous and active-high.
- Reset state:
  - FSM in IDLE; sample counter and timeout counter at 0.
  - y0 = y1 = y2 = TEMP_INIT.
  - All outputs 0: `read_cmos_temp`, `du`, `du_valid`, `p_sum`, `busy`, both error flags.
- Reset mid-step aborts immediately; there is no partial update.
- Sample timer:
  - While `enable` is high, the counter runs 0..SAMPLE_DIV-1 and wraps.
  - `tick` is the cycle in which cnt == SAMPLE_DIV-1.
  - `enable` low holds cnt at 0 and suppresses ticks. An in-flight step still completes.
- FSM states: IDLE, REQ, WAIT, MUL, ACC, OUT.
  - IDLE: on `tick` go to REQ.
  - REQ: `read_cmos_temp` = 1 for exactly this cycle; go to WAIT. Snapshot `pid_param` and `target_temp` here.
  - WAIT: `temp_valid` is sampled each cycle.
    - On `temp_valid`: y2 <= y1, y1 <= y0, y0 <= `temp_data`; go to MUL.
    - If TIMEOUT_CYC cycles elapse with no valid: set `timeout_err`, history unchanged, no `du_valid`, go to IDLE.
    - `temp_valid` in any other state is ignored.
  - MUL: 3 cycles. Issue, one per cycle and in this order, (T, a0), (Ti, a1), (Td, a2).
  - ACC: clear the accumulator at MUL entry. Add each product in the cycle it emerges, MULT_LAT cycles after issue.
  - OUT: `p_sum` and `du` registered, `du_valid` = 1 for one cycle; go to IDLE.
- Latency: `du_valid` is asserted exactly MULT_LAT+4 cycles after the cycle in which `temp_valid` was sampled high (7 cycles at the default).
- Tick while not IDLE: the tick is dropped, `overrun_err` is set, and the timer keeps running.
- `err_clr` is lower priority than a set event in the same cycle.
- Arithmetic:
  - a0 = y0 - y1.
  - a1 = y0 - target.
  - a2 = y0 + y2 - 2*y1, computed 19-bit signed.
  - Operands are zero-extended to signed. Each a* is saturated to 17-bit signed [-65536, 65535].
  - Coefficients are 4-bit unsigned. Products are 21-bit signed, exact.
  - The accumulator is 23-bit signed. `p_sum` is saturated to 21-bit signed [-1048576, 1048575].
- Quantization of `p` (= `p_sum`):
  - p > 512 → +3; 256 < p ≤ 512 → +2; 0 < p ≤ 256 → +1; p = 0 → 0.
  - -256 < p < 0 → -1; -512 < p ≤ -256 → -2; p ≤ -512 → -3.
- `du` holds its value between strobes.

Test Plan:
- Reset / hold: assert `rst` mid-MUL → next cycle FSM in IDLE, all outputs 0, y* = 0x7183. With `enable` = 0 for 10·SAMPLE_DIV cycles → no `read_cmos_temp`.
- Positive step: SAMPLE_DIV = 100, `pid_param` = 24'h000201, target = 0x7183, `temp_data` = 0x7190 one cycle after the request.
  - Expect a = 13, 13, 13; `p_sum` = 39; `du` = +1.
  - `du_valid` exactly 7 cycles after `temp_valid`.
- Second sample 0x7400 after the previous step:
  - Expect a0 = 624, a1 = 637, a2 = 611; `p_sum` = 1898; `du` = +3.
- Negative steps from reset, target = 0x7183, same `pid_param`:
  - temp 0x7180 → `p_sum` = -9, `du` = -1.
  - After a fresh reset, temp 0x7000 → `p_sum` = -1161, `du` = -3.
- Saturation: `pid_param` = 24'h000FFF, target = 0.
  - Drive samples 0xFFFF, then 0x0000, then 0xFFFF.
  - At the third step a2 raw = 131070 saturates to 65535; the sum saturates: `p_sum` = 1048575, `du` = +3.
- Errors: TIMEOUT_CYC = 16, no `temp_valid`.
  - `timeout_err` rises 16 cycles after WAIT entry; no `du_valid`; y* unchanged.
  - SAMPLE_DIV = 5 with the sensor answering late → `overrun_err` set.
  - `err_clr` clears both flags.

Source files
------------

// File: rtl/pid_step_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pid_step_sequencer                                                       |
// | One PID step per sample period: sensor read, history shift, three        |
// | coefficient products through one shared pipelined multiplier, quantized. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pid_step_sequencer #(
  parameter int          SAMPLE_DIV  = 20000000,
  parameter int          TIMEOUT_CYC = 1000,
  parameter int          MULT_LAT    = 3,
  parameter logic [15:0] TEMP_INIT   = 16'h7183
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        enable,
  input  logic [23:0] pid_param,
  input  logic [15:0] target_temp,
  output logic        read_cmos_temp,
  input  logic        temp_valid,
  input  logic [15:0] temp_data,
  output logic [3:0]  du,
  output logic        du_valid,
  output logic [20:0] p_sum,
  output logic        busy,
  output logic        timeout_err,
  output logic        overrun_err,
  input  logic        err_clr
);

  localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(SAMPLE_DIV - 1);
  localparam logic [TO_W-1:0]  c_to_max  = TO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_MUL  = 3'd3,
    S_ACC  = 3'd4,
    S_OUT  = 3'd5
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [TO_W-1:0]    r_tcnt;
  logic [1:0]         r_mcnt;
  logic [15:0]        r_y0, r_y1, r_y2;
  logic [15:0]        r_target;
  logic [3:0]         r_coef_t, r_coef_ti, r_coef_td;
  logic signed [22:0] r_acc;

  logic signed [20:0] r_mp [MULT_LAT];
  logic [MULT_LAT-1:0] r_mv;
  logic [MULT_LAT-1:0] r_ml;

  logic               w_tick;
  logic               w_to_set;
  logic               w_ov_set;
  logic signed [18:0] w_a0_raw, w_a1_raw, w_a2_raw;
  logic [3:0]         w_coef;
  logic signed [16:0] w_opnd;
  logic signed [21:0] w_coef_x, w_opnd_x, w_prod;
  logic signed [20:0] w_pout;
  logic               w_pout_v, w_pout_last;
  logic signed [22:0] w_acc_next;
  logic signed [20:0] w_psat;
  logic [3:0]         w_du;
  logic               w_unused_bits;

  assign w_unused_bits = ^pid_param[23:12];

  function automatic logic signed [16:0] sat17(input logic signed [18:0] v);
    if (v[18:16] == 3'b000 || v[18:16] == 3'b111) return v[16:0];
    else if (v[18])                                return 17'h10000;
    else                                           return 17'h0FFFF;
  endfunction

  function automatic logic signed [20:0] sat21(input logic signed [22:0] v);
    if (v[22:20] == 3'b000 || v[22:20] == 3'b111) return v[20:0];
    else if (v[22])                                return 21'h100000;
    else                                           return 21'h0FFFFF;
  endfunction

  function automatic logic [3:0] quant(input logic signed [20:0] p);
    if (p > 21'sd512)        return 4'd3;
    else if (p > 21'sd256)   return 4'd2;
    else if (p > 21'sd0)     return 4'd1;
    else if (p == 21'sd0)    return 4'd0;
    else if (p > -21'sd256)  return 4'hF;
    else if (p > -21'sd512)  return 4'hE;
    else                     return 4'hD;
  endfunction

  // Sample timer
  assign w_tick = enable && (r_cnt == c_cnt_max);

  always_ff @(posedge CLK) begin
    if (rst)                  r_cnt <= '0;
    else if (!enable || w_tick) r_cnt <= '0;
    else                      r_cnt <= r_cnt + 1'b1;
  end

  // Operands: zero-extended sensor codes, differences formed at 19 bits
  always_comb begin
    w_a0_raw = $signed({3'b000, r_y0}) - $signed({3'b000, r_y1});
    w_a1_raw = $signed({3'b000, r_y0}) - $signed({3'b000, r_target});
    w_a2_raw = $signed({3'b000, r_y0}) + $signed({3'b000, r_y2})
             - $signed({2'b00, r_y1, 1'b0});
  end

  always_comb begin
    w_coef = r_coef_td;
    w_opnd = sat17(w_a2_raw);
    case (r_mcnt)
      2'd0: begin w_coef = r_coef_t;  w_opnd = sat17(w_a0_raw); end
      2'd1: begin w_coef = r_coef_ti; w_opnd = sat17(w_a1_raw); end
      default: ;
    endcase
  end

  assign w_coef_x = {18'd0, w_coef};
  assign w_opnd_x = {{5{w_opnd[16]}}, w_opnd};
  assign w_prod   = w_coef_x * w_opnd_x;

  // Shared multiplier pipeline; product emerges MULT_LAT cycles after issue
  always_ff @(posedge CLK) begin
    r_mp[0] <= w_prod[20:0];
    for (int i = 1; i < MULT_LAT; i++) r_mp[i] <= r_mp[i-1];
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      r_mv <= '0;
      r_ml <= '0;
    end else begin
      r_mv[0] <= (r_state == S_MUL);
      r_ml[0] <= (r_state == S_MUL) && (r_mcnt == 2'd2);
      for (int i = 1; i < MULT_LAT; i++) begin
        r_mv[i] <= r_mv[i-1];
        r_ml[i] <= r_ml[i-1];
      end
    end
  end

  assign w_pout      = r_mp[MULT_LAT-1];
  assign w_pout_v    = r_mv[MULT_LAT-1];
  assign w_pout_last = r_ml[MULT_LAT-1];
  assign w_acc_next  = r_acc + {{2{w_pout[20]}}, w_pout};
  assign w_psat      = sat21(w_acc_next);
  assign w_du        = quant(w_psat);

  assign w_to_set = (r_state == S_WAIT) && !temp_valid && (r_tcnt == c_to_max);
  assign w_ov_set = w_tick && (r_state != S_IDLE);

  always_ff @(posedge CLK) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_tcnt         <= '0;
      r_mcnt         <= '0;
      r_y0           <= TEMP_INIT;
      r_y1           <= TEMP_INIT;
      r_y2           <= TEMP_INIT;
      r_target       <= '0;
      r_coef_t       <= '0;
      r_coef_ti      <= '0;
      r_coef_td      <= '0;
      r_acc          <= '0;
      read_cmos_temp <= 1'b0;
      du             <= '0;
      du_valid       <= 1'b0;
      p_sum          <= '0;
      busy           <= 1'b0;
      timeout_err    <= 1'b0;
      overrun_err    <= 1'b0;
    end else begin
      read_cmos_temp <= 1'b0;
      du_valid       <= 1'b0;
      if (w_pout_v) r_acc <= w_acc_next;

      // A set event wins over a clear in the same cycle
      if (w_to_set)     timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
      if (w_ov_set)     overrun_err <= 1'b1;
      else if (err_clr) overrun_err <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_tick) begin
            r_state        <= S_REQ;
            read_cmos_temp <= 1'b1;
            busy           <= 1'b1;
          end
        end
        S_REQ: begin
          r_coef_t  <= pid_param[3:0];
          r_coef_td <= pid_param[7:4];
          r_coef_ti <= pid_param[11:8];
          r_target  <= target_temp;
          r_tcnt    <= '0;
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          if (temp_valid) begin
            r_y2    <= r_y1;
            r_y1    <= r_y0;
            r_y0    <= temp_data;
            r_acc   <= '0;
            r_mcnt  <= '0;
            r_state <= S_MUL;
          end else if (w_to_set) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        S_MUL: begin
          r_mcnt <= r_mcnt + 1'b1;
          if (r_mcnt == 2'd2) r_state <= S_ACC;
        end
        S_ACC: begin
          if (w_pout_v && w_pout_last) begin
            p_sum    <= w_psat;
            du       <= w_du;
            du_valid <= 1'b1;
            r_state  <= S_OUT;
          end
        end
        S_OUT: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pid_step_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pid_step_sequencer                                                    |
// | Directed bench for pid_step_sequencer with hand-computed step results.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_pid_step_sequencer;

  logic        CLK = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [23:0] pid_param = 24'h000201;
  logic [15:0] target_temp = 16'h7183;
  logic        read_cmos_temp;
  logic        temp_valid = 1'b0;
  logic [15:0] temp_data = 16'h0000;
  logic [3:0]  du;
  logic        du_valid;
  logic [20:0] p_sum;
  logic        busy;
  logic        timeout_err;
  logic        overrun_err;
  logic        err_clr = 1'b0;

  logic        enable2 = 1'b0;
  logic        temp_valid2 = 1'b0;
  logic        read_cmos_temp2;
  logic [3:0]  du2;
  logic        du_valid2;
  logic [20:0] p_sum2;
  logic        busy2;
  logic        timeout_err2;
  logic        overrun_err2;

  int vectors = 0;
  int errors  = 0;

  always #5 CLK = ~CLK;

  pid_step_sequencer #(
    .SAMPLE_DIV(100), .TIMEOUT_CYC(16), .MULT_LAT(3), .TEMP_INIT(16'h7183)
  ) dut (
    .CLK(CLK), .rst(rst), .enable(enable), .pid_param(pid_param),
    .target_temp(target_temp), .read_cmos_temp(read_cmos_temp),
    .temp_valid(temp_valid), .temp_data(temp_data), .du(du), .du_valid(du_valid),
    .p_sum(p_sum), .busy(busy), .timeout_err(timeout_err),
    .overrun_err(overrun_err), .err_clr(err_clr)
  );

  pid_step_sequencer #(
    .SAMPLE_DIV(5), .TIMEOUT_CYC(16), .MULT_LAT(3), .TEMP_INIT(16'h7183)
  ) dut_ov (
    .CLK(CLK), .rst(rst), .enable(enable2), .pid_param(pid_param),
    .target_temp(target_temp), .read_cmos_temp(read_cmos_temp2),
    .temp_valid(temp_valid2), .temp_data(temp_data), .du(du2), .du_valid(du_valid2),
    .p_sum(p_sum2), .busy(busy2), .timeout_err(timeout_err2),
    .overrun_err(overrun_err2), .err_clr(err_clr)
  );

  // Stimulus only: waits for the request, answers one cycle later, times du_valid
  task automatic run_step(input logic [15:0] temp, output bit ok, output int lat,
                          output logic rd_after);
    ok = 0; lat = 0; rd_after = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge CLK);
      if (read_cmos_temp === 1'b1) ok = 1;
    end
    enable = 1'b0;
    if (!ok) return;
    @(negedge CLK);
    rd_after   = read_cmos_temp;
    temp_valid = 1'b1;
    temp_data  = temp;
    ok = 0;
    for (int i = 1; i <= 40 && !ok; i++) begin
      @(negedge CLK);
      temp_valid = 1'b0;
      if (du_valid === 1'b1) begin ok = 1; lat = i; end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge CLK);
    rst = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge CLK);
    vectors++;
    if ({read_cmos_temp, du_valid, busy, timeout_err, overrun_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b, expected 00000",
               {read_cmos_temp, du_valid, busy, timeout_err, overrun_err});
    end
    vectors++;
    if (du !== 4'd0 || p_sum !== 21'd0) begin
      errors++;
      $display("FAIL reset_data: got du=%0d p_sum=%0d, expected 0/0", du, p_sum);
    end
    vectors++;
    if (dut.r_y0 !== 16'h7183 || dut.r_y1 !== 16'h7183 || dut.r_y2 !== 16'h7183) begin
      errors++;
      $display("FAIL reset_history: got %h %h %h, expected 7183 x3",
               dut.r_y0, dut.r_y1, dut.r_y2);
    end
    rst = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_hold();
    int reads = 0;
    enable = 1'b0;
    enable2 = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge CLK);
      if (read_cmos_temp === 1'b1 || read_cmos_temp2 === 1'b1) reads++;
    end
    vectors++;
    if (reads != 0) begin
      errors++;
      $display("FAIL hold_no_read: got %0d requests, expected 0", reads);
    end
  endtask

  task automatic test_positive_step();
    bit ok; int lat; logic rd;
    pid_param = 24'h000201;
    target_temp = 16'h7183;
    run_step(16'h7190, ok, lat, rd);
    vectors++;
    if (!ok) begin errors++; $display("FAIL pos1_done: du_valid got 0, expected 1"); end
    vectors++;
    if (rd !== 1'b0) begin errors++; $display("FAIL pos1_read_width: got %b, expected 0", rd); end
    vectors++;
    if (lat != 7) begin errors++; $display("FAIL pos1_latency: got %0d, expected 7", lat); end
    vectors++;
    if (p_sum !== 21'd39) begin
      errors++; $display("FAIL pos1_p_sum: got %0d, expected 39", $signed(p_sum));
    end
    vectors++;
    if (du !== 4'd1) begin errors++; $display("FAIL pos1_du: got %0d, expected 1", du); end
    @(negedge CLK);
    vectors++;
    if (du_valid !== 1'b0 || du !== 4'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL pos1_hold: got valid=%b du=%0d busy=%b, expected 0/1/0", du_valid, du, busy);
    end

    run_step(16'h7400, ok, lat, rd);
    vectors++;
    if (!ok) begin errors++; $display("FAIL pos2_done: du_valid got 0, expected 1"); end
    vectors++;
    if (p_sum !== 21'd1898) begin
      errors++; $display("FAIL pos2_p_sum: got %0d, expected 1898", $signed(p_sum));
    end
    vectors++;
    if (du !== 4'd3) begin errors++; $display("FAIL pos2_du: got %0d, expected 3", du); end
  endtask

  task automatic test_reset_mid_mul();
    bit ok = 0;
    enable = 1'b1;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge CLK);
      if (read_cmos_temp === 1'b1) ok = 1;
    end
    enable = 1'b0;
    vectors++;
    if (!ok) begin errors++; $display("FAIL midrst_req: request got 0, expected 1"); end
    @(negedge CLK);
    temp_valid = 1'b1; temp_data = 16'h7300;
    @(negedge CLK);
    temp_valid = 1'b0;
    @(negedge CLK);
    vectors++;
    if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy: got %b, expected 1", busy); end
    rst = 1'b1;
    @(negedge CLK);
    vectors++;
    if ({read_cmos_temp, du_valid, busy, timeout_err, overrun_err} !== 5'b0 ||
        du !== 4'd0 || p_sum !== 21'd0) begin
      errors++;
      $display("FAIL midrst_outputs: got flags=%b du=%0d p_sum=%0d, expected all 0",
               {read_cmos_temp, du_valid, busy, timeout_err, overrun_err}, du, p_sum);
    end
    vectors++;
    if (dut.r_y0 !== 16'h7183 || dut.r_y1 !== 16'h7183 || dut.r_y2 !== 16'h7183) begin
      errors++;
      $display("FAIL midrst_history: got %h %h %h, expected 7183 x3",
               dut.r_y0, dut.r_y1, dut.r_y2);
    end
    rst = 1'b0;
    ok = 0;
    repeat (12) begin
      @(negedge CLK);
      if (du_valid === 1'b1) ok = 1;
    end
    vectors++;
    if (ok) begin errors++; $display("FAIL midrst_no_strobe: du_valid got 1, expected 0"); end
  endtask

  task automatic test_negative_step();
    bit ok; int lat; logic rd;
    pid_param = 24'h000201;
    target_temp = 16'h7183;
    do_reset();
    run_step(16'h7180, ok, lat, rd);
    vectors++;
    if (!ok || p_sum !== 21'(-9)) begin
      errors++; $display("FAIL neg1_p_sum: got %0d (done=%b), expected -9", $signed(p_sum), ok);
    end
    vectors++;
    if (du !== 4'hF) begin errors++; $display("FAIL neg1_du: got %0d, expected -1", $signed(du)); end
    do_reset();
    run_step(16'h7000, ok, lat, rd);
    vectors++;
    if (!ok || p_sum !== 21'(-1161)) begin
      errors++; $display("FAIL neg2_p_sum: got %0d (done=%b), expected -1161", $signed(p_sum), ok);
    end
    vectors++;
    if (du !== 4'hD) begin errors++; $display("FAIL neg2_du: got %0d, expected -3", $signed(du)); end
  endtask

  task automatic test_saturation();
    bit ok; int lat; logic rd;
    pid_param = 24'h000FFF;
    target_temp = 16'h0000;
    do_reset();
    run_step(16'hFFFF, ok, lat, rd);
    run_step(16'h0000, ok, lat, rd);
    vectors++;
    if (!ok || p_sum !== 21'h100000 || du !== 4'hD) begin
      errors++;
      $display("FAIL sat_neg: got p_sum=%0d du=%0d, expected -1048576/-3",
               $signed(p_sum), $signed(du));
    end
    run_step(16'hFFFF, ok, lat, rd);
    vectors++;
    if (!ok || p_sum !== 21'd1048575) begin
      errors++; $display("FAIL sat_pos_p_sum: got %0d, expected 1048575", $signed(p_sum));
    end
    vectors++;
    if (du !== 4'd3) begin errors++; $display("FAIL sat_pos_du: got %0d, expected 3", du); end
  endtask

  task automatic test_timeout();
    bit ok = 0; bit strobe = 0;
    pid_param = 24'h000201;
    target_temp = 16'h7183;
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge CLK);
      if (read_cmos_temp === 1'b1) ok = 1;
    end
    enable = 1'b0;
    vectors++;
    if (!ok) begin errors++; $display("FAIL to_req: request got 0, expected 1"); end
    for (int k = 1; k <= 17; k++) begin
      @(negedge CLK);
      if (du_valid === 1'b1) strobe = 1;
      if (k == 16) begin
        vectors++;
        if (timeout_err !== 1'b0) begin
          errors++; $display("FAIL to_early: got %b, expected 0", timeout_err);
        end
      end
      if (k == 17) begin
        vectors++;
        if (timeout_err !== 1'b1 || busy !== 1'b0) begin
          errors++;
          $display("FAIL to_set: got err=%b busy=%b, expected 1/0", timeout_err, busy);
        end
      end
    end
    vectors++;
    if (strobe) begin errors++; $display("FAIL to_no_strobe: du_valid got 1, expected 0"); end
    vectors++;
    if (dut.r_y0 !== 16'h7183 || dut.r_y1 !== 16'h7183 || dut.r_y2 !== 16'h7183) begin
      errors++;
      $display("FAIL to_history: got %h %h %h, expected 7183 x3",
               dut.r_y0, dut.r_y1, dut.r_y2);
    end
  endtask

  task automatic test_overrun();
    bit ok = 0;
    enable2 = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge CLK);
      if (read_cmos_temp2 === 1'b1) ok = 1;
    end
    vectors++;
    if (!ok) begin errors++; $display("FAIL ov_req: request got 0, expected 1"); end
    repeat (9) @(negedge CLK);
    temp_valid2 = 1'b1;
    temp_data = 16'h7200;
    enable2 = 1'b0;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge CLK);
      temp_valid2 = 1'b0;
      if (du_valid2 === 1'b1) ok = 1;
    end
    vectors++;
    if (!ok) begin errors++; $display("FAIL ov_done: du_valid got 0, expected 1"); end
    vectors++;
    if (overrun_err2 !== 1'b1 || timeout_err2 !== 1'b0) begin
      errors++;
      $display("FAIL ov_flags: got ov=%b to=%b, expected 1/0", overrun_err2, timeout_err2);
    end
    vectors++;
    if (overrun_err !== 1'b0) begin
      errors++; $display("FAIL ov_idle_dut: got %b, expected 0", overrun_err);
    end
  endtask

  task automatic test_err_clr();
    repeat (3) @(negedge CLK);
    err_clr = 1'b1;
    @(negedge CLK);
    err_clr = 1'b0;
    vectors++;
    if (timeout_err !== 1'b0 || overrun_err2 !== 1'b0) begin
      errors++;
      $display("FAIL err_clr: got to=%b ov=%b, expected 0/0", timeout_err, overrun_err2);
    end
  endtask

  initial begin
    test_reset();
    test_hold();
    test_positive_step();
    test_reset_mid_mul();
    test_negative_step();
    test_saturation();
    test_timeout();
    test_overrun();
    test_err_clr();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
